// File: rtl/uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : uart_tx_fifo
// Brief   : Byte FIFO feeding an 8N1 asynchronous serial transmitter (LSB first).
// Revision: 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_AW      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] i_data,
    input  logic       i_data_v,
    output logic       o_tx,
    output logic       o_busy,
    output logic       o_full,
    output logic       o_overflow
);

    localparam int c_depth  = 1 << FIFO_AW;
    localparam int c_baud_w = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_start = 2'd1;
    localparam logic [1:0] c_st_data  = 2'd2;
    localparam logic [1:0] c_st_stop  = 2'd3;

    logic [7:0]         r_mem [c_depth];
    logic [FIFO_AW:0]   r_wr_ptr;
    logic [FIFO_AW:0]   r_rd_ptr;
    logic               r_overflow;

    logic [1:0]         r_state;
    logic [c_baud_w-1:0] r_baud;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic               r_tx;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_baud_done;
    logic [7:0]         w_head;
    logic [1:0]         w_state_nxt;
    logic [c_baud_w-1:0] w_baud_nxt;
    logic [2:0]         w_bit_nxt;
    logic [7:0]         w_shift_nxt;
    logic               w_tx_nxt;

    // Wrap bit distinguishes full from empty when the index bits match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[FIFO_AW] != r_rd_ptr[FIFO_AW]) &&
                     (r_wr_ptr[FIFO_AW-1:0] == r_rd_ptr[FIFO_AW-1:0]);
    assign w_push  = i_data_v && !w_full;
    assign w_head  = r_mem[r_rd_ptr[FIFO_AW-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[FIFO_AW-1:0]] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_data_v && w_full) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_baud  <= w_baud_nxt;
            r_bit   <= w_bit_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
        end
    end

    assign w_baud_done = (r_baud == c_baud_last);

    // Line level is computed for the next state so o_tx comes straight from a flop.
    always_comb begin
        w_state_nxt = r_state;
        w_baud_nxt  = w_baud_done ? '0 : r_baud + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;
        case (r_state)
            c_st_idle: begin
                w_baud_nxt = '0;
                w_tx_nxt   = 1'b1;
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_head;
                    w_state_nxt = c_st_start;
                    w_tx_nxt    = 1'b0;
                end
            end
            c_st_start: begin
                if (w_baud_done) begin
                    w_state_nxt = c_st_data;
                    w_bit_nxt   = '0;
                    w_tx_nxt    = r_shift[0];
                end
            end
            c_st_data: begin
                if (w_baud_done) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = c_st_stop;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_bit_nxt = r_bit + 3'd1;
                        w_tx_nxt  = r_shift[1];
                    end
                end
            end
            c_st_stop: begin
                // Chain straight into the next start bit when data is waiting.
                if (w_baud_done) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_head;
                        w_state_nxt = c_st_start;
                        w_tx_nxt    = 1'b0;
                    end else begin
                        w_state_nxt = c_st_idle;
                        w_tx_nxt    = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
                w_tx_nxt    = 1'b1;
            end
        endcase
    end

    assign o_tx       = r_tx;
    assign o_busy     = !w_empty || (r_state != c_st_idle);
    assign o_full     = w_full;
    assign o_overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_fifo
// Brief   : Scoreboard bench for uart_tx_fifo; a line decoder checks each frame.
// Revision: 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    localparam int N  = 4;
    localparam int AW = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] i_data = 8'h00;
    logic       i_data_v = 1'b0;
    logic       o_tx;
    logic       o_busy;
    logic       o_full;
    logic       o_overflow;

    uart_tx_fifo #(.CLKS_PER_BIT(N), .FIFO_AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_data     (i_data),
        .i_data_v   (i_data_v),
        .o_tx       (o_tx),
        .o_busy     (o_busy),
        .o_full     (o_full),
        .o_overflow (o_overflow)
    );

    always #5 clk = ~clk;

    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         n_rx = 0;
    logic [7:0] exp_q[$];
    int         starts[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (cyc > 95000) begin
            $display("FAIL watchdog cycles=%0d required<95000", cyc);
            $fatal(1);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_cmp++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s got=%0h required=%0h", name, got, req);
        end
    endtask

    // Line monitor: detects start, samples mid-bit, compares against the scoreboard.
    bit         m_active = 1'b0;
    int         m_cnt = 0;
    logic [9:0] m_sh;
    logic [7:0] m_exp;

    always @(negedge clk) begin
        if (rst) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            if (o_tx === 1'b0) begin
                m_active = 1'b1;
                m_cnt    = 0;
                m_sh     = '0;
                starts.push_back(cyc);
            end
        end else begin
            m_cnt++;
            if (m_cnt % N == N / 2) m_sh[m_cnt / N] = o_tx;
            if (m_cnt == 9 * N + N / 2) begin
                m_active = 1'b0;
                n_rx++;
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL frame_unexpected got=%b required=none", m_sh);
                end else begin
                    m_exp = exp_q.pop_front();
                    if (m_sh !== {1'b1, m_exp, 1'b0}) begin
                        n_err++;
                        $display("FAIL frame got=%b required=%b", m_sh, {1'b1, m_exp, 1'b0});
                    end
                end
            end
        end
    end

    task automatic write_byte(input logic [7:0] d, input bit accepted);
        i_data   = d;
        i_data_v = 1'b1;
        if (accepted) exp_q.push_back(d);
        @(posedge clk);
        #1;
        i_data_v = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int k = 0;
        while (n_rx < target && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("frames_received", n_rx, target);
    endtask

    logic [9:0] pat_6c = 10'b1011011000;
    int         bad;
    int         base;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle after reset
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (o_tx !== 1'b1 || o_busy !== 1'b0 || o_full !== 1'b0) bad++;
        end
        check("idle_cycles_bad", bad, 0);
        check("reset_tx", o_tx, 1);
        check("reset_busy", o_busy, 0);
        check("reset_full", o_full, 0);
        check("reset_overflow", o_overflow, 0);

        // Single 'l' with exact bit timing
        @(posedge clk);
        #1;
        write_byte(8'h6C, 1'b1);
        @(negedge clk);
        check("tx_before_latency", o_tx, 1);
        check("busy_after_write", o_busy, 1);
        for (int c = 0; c < 10 * N; c++) begin
            @(negedge clk);
            if (c % N == 0) check($sformatf("bit%0d_6c", c / N), o_tx, pat_6c[c / N]);
        end
        @(negedge clk);
        check("busy_after_frame", o_busy, 0);
        check("tx_after_frame", o_tx, 1);
        wait_frames(1, 50);

        // Back-to-back frames with no idle gap
        @(posedge clk);
        #1;
        starts.delete();
        base = n_rx;
        write_byte(8'h1B, 1'b1);
        write_byte(8'h0D, 1'b1);
        write_byte(8'h0A, 1'b1);
        wait_frames(base + 3, 200);
        check("b2b_starts", starts.size(), 3);
        if (starts.size() == 3) begin
            check("gap_1_2", starts[1] - starts[0], 10 * N);
            check("gap_2_3", starts[2] - starts[1], 10 * N);
        end
        check("b2b_overflow", o_overflow, 0);

        // Fill past capacity: frame 1 in flight, four buffered, sixth dropped
        repeat (10) @(posedge clk);
        #1;
        base = n_rx;
        write_byte(8'h31, 1'b1);
        write_byte(8'h32, 1'b1);
        write_byte(8'h33, 1'b1);
        write_byte(8'h34, 1'b1);
        check("full_before_4th", o_full, 0);
        write_byte(8'h35, 1'b1);
        check("full_after_4th", o_full, 1);
        check("overflow_before_drop", o_overflow, 0);
        write_byte(8'h36, 1'b0);
        check("overflow_after_drop", o_overflow, 1);
        check("full_after_drop", o_full, 1);
        wait_frames(base + 5, 5 * 10 * N + 60);
        check("overflow_sticky", o_overflow, 1);

        // Reset mid-DATA aborts the frame
        repeat (5) @(posedge clk);
        #1;
        write_byte(8'h55, 1'b1);
        repeat (12) @(posedge clk);
        #1;
        check("busy_mid_frame", o_busy, 1);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_mid_tx", o_tx, 1);
        check("rst_mid_busy", o_busy, 0);
        check("rst_mid_overflow", o_overflow, 0);
        check("rst_mid_full", o_full, 0);
        base = n_rx;
        write_byte(8'hAA, 1'b1);
        wait_frames(base + 1, 60);

        // Long paced stream exercising pointer wrap
        repeat (5) @(posedge clk);
        #1;
        base = n_rx;
        for (int i = 0; i < 1024; i++) begin
            write_byte(8'h6C, 1'b1);
            repeat (10 * N - 1) @(posedge clk);
            #1;
        end
        wait_frames(base + 1024, 100);
        check("stream_overflow", o_overflow, 0);
        check("scoreboard_empty", exp_q.size(), 0);
        repeat (5) @(posedge clk);
        #1;
        check("stream_busy_end", o_busy, 0);
        check("stream_full_end", o_full, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
